// File: rtl/sub_halt_arb_pkg.sv
// Shared definitions for the sub-CPU halt arbiter: state encoding,
// parameter defaults and the main-bus access decode.
package sub_halt_arb_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALT_WAIT,
      ST_HALTED,
      ST_RELEASE
   } arb_state_e;

   localparam int SETTLE_DEFAULT  = 2;
   localparam int TIMEOUT_DEFAULT = 1023;
   localparam int SETTLE_W        = 4;
   localparam int WAIT_W          = 10;

   // A main access is a cycle with both the window select and strobe low
   function automatic logic mainAccess(input logic mshrN, input logic mstbN);
      return !mshrN && !mstbN;
   endfunction

endpackage

// File: rtl/sub_halt_arb_if.sv
// Halt/steering signal bundle between the main-side logic, the sub 6809
// and the halt arbiter.
interface sub_halt_arb_if;

   logic HALT_REQ;
   logic SUB_BA;
   logic SUB_BS;
   logic MSHRn;
   logic MSTBn;
   logic SHALTn;
   logic SHALTACn;
   logic SUBSELn;
   logic BUSY;
   logic TOUT;

   modport slave (
      input  HALT_REQ, SUB_BA, SUB_BS, MSHRn, MSTBn,
      output SHALTn, SHALTACn, SUBSELn, BUSY, TOUT
   );

   modport master (
      output HALT_REQ, SUB_BA, SUB_BS, MSHRn, MSTBn,
      input  SHALTn, SHALTACn, SUBSELn, BUSY, TOUT
   );

endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// instead of wrapping.
module sat_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/sub_halt_arb.sv
// Halts the sub 6809, waits for BA/BS to settle, then grants the main CPU
// the shared RAM; releases the sub only once any main strobe has finished.
module sub_halt_arb
   import sub_halt_arb_pkg::*;
#(
   parameter int SETTLE  = SETTLE_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input logic           CLKSYS,
   input logic           RSTn,
   sub_halt_arb_if.slave bus
);

   // Counters are compared one short of the target so the transition lands
   // on the same edge at which the counter would reach it.
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
   localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(TIMEOUT - 1);

   arb_state_e          state_q, state_d;
   logic                tout_q, tout_d;
   logic                hreq_q;
   logic [SETTLE_W-1:0] settle_q;
   logic [WAIT_W-1:0]   wait_q;
   logic                inWait;
   logic                bothUp;
   logic                access;

   assign inWait = (state_q == ST_HALT_WAIT);
   assign bothUp = bus.SUB_BA && bus.SUB_BS;
   assign access = mainAccess(bus.MSHRn, bus.MSTBn);

   sat_cnt #(.W(SETTLE_W)) u_settle_cnt (
      .clk   (CLKSYS),
      .rst_n (RSTn),
      .clr_i (!inWait || !bothUp),
      .inc_i (inWait && bothUp),
      .cnt_o (settle_q)
   );

   sat_cnt #(.W(WAIT_W)) u_wait_cnt (
      .clk   (CLKSYS),
      .rst_n (RSTn),
      .clr_i (!inWait),
      .inc_i (inWait),
      .cnt_o (wait_q)
   );

   always_ff @(posedge CLKSYS or negedge RSTn) begin
      if (!RSTn) begin
         state_q <= ST_RUN;
         tout_q  <= 1'b0;
         hreq_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tout_q  <= tout_d;
         hreq_q  <= bus.HALT_REQ;
      end
   end

   // Losing BA/BS while halted outranks a release so the grant drops first;
   // a release waits for the current main strobe to end.
   always_comb begin
      state_d = state_q;
      tout_d  = tout_q;
      unique case (state_q)
         ST_RUN: begin
            if (bus.HALT_REQ) begin
               state_d = ST_HALT_WAIT;
               if (!hreq_q) begin
                  tout_d = 1'b0;
               end
            end
         end
         ST_HALT_WAIT: begin
            if (!bus.HALT_REQ) begin
               state_d = ST_RUN;
            end else begin
               if (bothUp && (settle_q >= SETTLE_LAST)) begin
                  state_d = ST_HALTED;
               end
               if (wait_q == WAIT_LAST) begin
                  tout_d = 1'b1;
               end
            end
         end
         ST_HALTED: begin
            if (!bothUp) begin
               state_d = ST_HALT_WAIT;
            end else if (!bus.HALT_REQ && !access) begin
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign bus.SHALTn   = (state_q == ST_RUN);
   assign bus.SHALTACn = (state_q != ST_HALTED);
   assign bus.BUSY     = bus.SHALTACn;
   assign bus.SUBSELn  = (state_q == ST_HALTED) ? (bus.MSHRn || bus.MSTBn) : 1'b1;
   assign bus.TOUT     = tout_q;

endmodule

// File: tb/tb_sub_halt_arb.sv
// Self-checking bench for sub_halt_arb: per-cycle vector table through a
// scoreboard queue, plus reset-related sequences.
module tb_sub_halt_arb;

   typedef struct {
      string name;
      logic  req, ba, bs, mshrN, mstbN;
      logic  shaltN, shaltacN, subselN, tout;
   } vec_t;

   typedef struct {
      string name;
      logic  shaltN, shaltacN, subselN, busy, tout;
   } exp_t;

   logic CLKSYS;
   logic RSTn;
   int   testCount = 0;
   int   failCount = 0;
   vec_t vecs[$];
   exp_t sbQueue[$];

   sub_halt_arb_if bus();

   sub_halt_arb #(.SETTLE(2), .TIMEOUT(8)) dut (
      .CLKSYS (CLKSYS),
      .RSTn   (RSTn),
      .bus    (bus)
   );

   initial begin
      CLKSYS = 1'b0;
      forever #5 CLKSYS = ~CLKSYS;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "[TB] watchdog");
   end

   task automatic addVec(input string name, input logic req, ba, bs, mshrN, mstbN,
                         input logic shaltN, shaltacN, subselN, tout);
      vec_t v;
      v.name = name; v.req = req; v.ba = ba; v.bs = bs;
      v.mshrN = mshrN; v.mstbN = mstbN;
      v.shaltN = shaltN; v.shaltacN = shaltacN; v.subselN = subselN; v.tout = tout;
      vecs.push_back(v);
   endtask

   // BUSY must mirror SHALTACn in every state
   task automatic pushExp(input string name, input logic shaltN, shaltacN, subselN, tout);
      exp_t e;
      e.name = name; e.shaltN = shaltN; e.shaltacN = shaltacN;
      e.subselN = subselN; e.busy = shaltacN; e.tout = tout;
      sbQueue.push_back(e);
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.HALT_REQ = v.req;
      bus.SUB_BA   = v.ba;
      bus.SUB_BS   = v.bs;
      bus.MSHRn    = v.mshrN;
      bus.MSTBn    = v.mstbN;
      pushExp(v.name, v.shaltN, v.shaltacN, v.subselN, v.tout);
   endtask

   task automatic checkOutput();
      exp_t e;
      testCount++;
      if (sbQueue.size() == 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard_empty: got no expected entry, required one");
      end else begin
         e = sbQueue.pop_front();
         if ({bus.SHALTn, bus.SHALTACn, bus.SUBSELn, bus.BUSY, bus.TOUT} !==
             {e.shaltN, e.shaltacN, e.subselN, e.busy, e.tout}) begin
            failCount++;
            $display("[TB] FAIL %s: got SHALTn=%b SHALTACn=%b SUBSELn=%b BUSY=%b TOUT=%b, required %b %b %b %b %b",
                     e.name, bus.SHALTn, bus.SHALTACn, bus.SUBSELn, bus.BUSY, bus.TOUT,
                     e.shaltN, e.shaltacN, e.subselN, e.busy, e.tout);
         end
      end
   endtask

   task automatic buildTable();
      //      name            req ba bs shr stb  shn acn sel tout
      addVec("run_idle",       0, 0, 0, 1, 1,   1, 1, 1, 0);
      addVec("run_req",        1, 0, 0, 1, 1,   1, 1, 1, 0);
      addVec("wait_enter",     1, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("wait_settle",    1, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("halted_ack",     1, 1, 1, 1, 1,   0, 0, 1, 0);
      addVec("access_one",     1, 1, 1, 0, 0,   0, 0, 0, 0);
      addVec("access_gone",    1, 1, 1, 1, 1,   0, 0, 1, 0);
      addVec("mshr_only",      1, 1, 1, 0, 1,   0, 0, 1, 0);
      addVec("access_start",   1, 1, 1, 0, 0,   0, 0, 0, 0);
      addVec("req_drop_acc",   0, 1, 1, 0, 0,   0, 0, 0, 0);
      addVec("access_hold",    0, 1, 1, 0, 0,   0, 0, 0, 0);
      addVec("strobe_end",     0, 1, 1, 0, 1,   0, 0, 1, 0);
      addVec("release",        0, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("run_after_rel",  0, 1, 1, 1, 1,   1, 1, 1, 0);
      addVec("run_req2",       1, 1, 1, 1, 1,   1, 1, 1, 0);
      addVec("wait2_a",        1, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("wait2_b",        1, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("halted2",        1, 1, 1, 1, 1,   0, 0, 1, 0);
      addVec("bs_drop_acc",    1, 1, 0, 0, 0,   0, 0, 0, 0);
      addVec("rewait_forced",  1, 1, 1, 0, 0,   0, 1, 1, 0);
      addVec("rewait_settle",  1, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("reack",          1, 1, 1, 1, 1,   0, 0, 1, 0);
      addVec("halted_req0",    0, 1, 1, 1, 1,   0, 0, 1, 0);
      addVec("release_req1",   1, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("run_then_wait",  1, 1, 1, 1, 1,   1, 1, 1, 0);
      addVec("wait3",          1, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("wait3_req_drop", 0, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("run3",           0, 0, 0, 1, 1,   1, 1, 1, 0);
      addVec("to_req",         1, 0, 0, 1, 1,   1, 1, 1, 0);
      for (int i = 0; i < 8; i++) begin
         addVec($sformatf("to_wait_%0d", i), 1, 0, 0, 1, 1, 0, 1, 1, 0);
      end
      addVec("tout_set",       1, 0, 0, 1, 1,   0, 1, 1, 1);
      addVec("tout_sticky",    1, 0, 0, 1, 1,   0, 1, 1, 1);
      addVec("tout_req_drop",  0, 0, 0, 1, 1,   0, 1, 1, 1);
      addVec("tout_in_run",    0, 0, 0, 1, 1,   1, 1, 1, 1);
      addVec("tout_rise",      1, 0, 0, 1, 1,   1, 1, 1, 1);
      addVec("tout_cleared",   1, 0, 0, 1, 1,   0, 1, 1, 0);
      addVec("wait4_drop",     0, 0, 0, 1, 1,   0, 1, 1, 0);
      addVec("run4",           0, 0, 0, 1, 1,   1, 1, 1, 0);
      addVec("run5_req",       1, 1, 1, 1, 1,   1, 1, 1, 0);
      addVec("wait5_a",        1, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("wait5_b",        1, 1, 1, 1, 1,   0, 1, 1, 0);
      addVec("halted5_acc",    1, 1, 1, 0, 0,   0, 0, 0, 0);
   endtask

   initial begin
      RSTn         = 1'b0;
      bus.HALT_REQ = 1'b0;
      bus.SUB_BA   = 1'b0;
      bus.SUB_BS   = 1'b0;
      bus.MSHRn    = 1'b1;
      bus.MSTBn    = 1'b1;

      repeat (2) @(negedge CLKSYS);
      pushExp("reset_values", 1, 1, 1, 0);
      checkOutput();

      bus.HALT_REQ = 1'b1;
      @(negedge CLKSYS);
      pushExp("reset_hold_req", 1, 1, 1, 0);
      checkOutput();

      // HALT_REQ held across reset release enters HALT_WAIT on the first edge
      @(posedge CLKSYS); #1;
      RSTn = 1'b1;
      @(negedge CLKSYS);
      pushExp("rst_release_run", 1, 1, 1, 0);
      checkOutput();
      @(negedge CLKSYS);
      pushExp("first_edge_wait", 0, 1, 1, 0);
      checkOutput();
      @(posedge CLKSYS); #1;
      bus.HALT_REQ = 1'b0;
      @(negedge CLKSYS);
      pushExp("wait_req_drop", 0, 1, 1, 0);
      checkOutput();
      @(negedge CLKSYS);
      pushExp("back_to_run", 1, 1, 1, 0);
      checkOutput();

      buildTable();
      foreach (vecs[i]) begin
         @(posedge CLKSYS); #1;
         applyStimulus(vecs[i]);
         @(negedge CLKSYS);
         checkOutput();
      end

      // Asynchronous reset while halted with an access in flight
      #2;
      RSTn = 1'b0;
      #1;
      pushExp("async_reset_halted", 1, 1, 1, 0);
      checkOutput();
      bus.HALT_REQ = 1'b0;
      bus.MSHRn    = 1'b1;
      bus.MSTBn    = 1'b1;
      repeat (2) @(negedge CLKSYS);
      pushExp("reset_hold_clocked", 1, 1, 1, 0);
      checkOutput();
      @(posedge CLKSYS); #1;
      RSTn = 1'b1;
      repeat (3) @(negedge CLKSYS);
      pushExp("idle_after_reset", 1, 1, 1, 0);
      checkOutput();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/sub_halt_arb.md
SUB_HALT_ARB -- requirements
Module: sub_halt_arb

Interface
REQ-001 Parameter SETTLE, default 2, meaning: cycles that BA=BS=1 must hold before the halt is acknowledged (range 1..15).
REQ-002 Parameter TIMEOUT, default 1023, meaning: cycles allowed in HALT_WAIT before TOUT is flagged (10-bit).
REQ-003 CLKSYS  input  1  system clock; all state updates on the rising edge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 HALT_REQ  input  1  main-side halt request (sub-control register bit 7), level.
REQ-006 SUB_BA  input  1  sub 6809 BA pin.
REQ-007 SUB_BS  input  1  sub 6809 BS pin.
REQ-008 MSHRn  input  1  main CPU is addressing the shared-RAM window, active-low.
REQ-009 MSTBn  input  1  main bus-cycle strobe, active-low; a main access is one MSHRn=0 and MSTBn=0 cycle.
REQ-010 SHALTn  output  1  HALT drive to the sub 6809, active-low.
REQ-011 SHALTACn  output  1  halt acknowledged; steers the shared-RAM address mux, active-low.
REQ-012 SUBSELn  output  1  main granted the shared RAM this cycle, active-low.
REQ-013 BUSY  output  1  main-readable status; 1 whenever SHALTACn=1.
REQ-014 TOUT  output  1  sticky halt-timeout flag.

Function
REQ-015 The FSM SHALL have four states: RUN, HALT_WAIT, HALTED, RELEASE.
REQ-016 RUN: SHALTn=1, SHALTACn=1; on HALT_REQ=1 go to HALT_WAIT and assert SHALTn=0 in the same registered update.
REQ-017 HALT_WAIT: SHALTn=0; a 4-bit settle counter increments while SUB_BA=SUB_BS=1 and clears to 0 when either is 0.
REQ-018 HALT_WAIT: when the settle counter reaches SETTLE, go to HALTED; SHALTACn goes 0 on that edge.
REQ-019 HALT_WAIT: a 10-bit wait counter counts every cycle; when it reaches TOUT, TOUT is set to 1 and the FSM stays in HALT_WAIT.
REQ-020 HALT_WAIT: if HALT_REQ drops, go to RUN next cycle (SHALTn=1) and clear both counters; TOUT is unaffected.
REQ-021 HALTED: SHALTn=0, SHALTACn=0; SUBSELn = MSHRn | MSTBn (combinational, zero latency).
REQ-022 HALTED: if SUB_BA or SUB_BS drops, go to HALT_WAIT, SHALTACn=1 next edge, and SUBSELn is forced to 1 from that edge on.
REQ-023 HALTED: if HALT_REQ drops with no main access in progress (MSHRn|MSTBn=1), go to RELEASE.
REQ-024 HALTED: if HALT_REQ drops while an access is in progress, stay in HALTED until the strobe ends, then go to RELEASE; a main write is never truncated.
REQ-025 RELEASE: SHALTACn=1 and SUBSELn=1 immediately; SHALTn=0 for exactly one cycle; then RUN with SHALTn=1.
REQ-026 RELEASE: if HALT_REQ is 1 again during RELEASE, the FSM still goes to RUN first, then re-enters HALT_WAIT on the following edge.
REQ-027 SUBSELn SHALL be 1 in every state other than HALTED.
REQ-028 TOUT is cleared only by reset, or by a HALT_REQ rising edge observed in RUN.
REQ-029 Counters SHALL saturate and never wrap.

Reset
REQ-030 While RSTn=0: state=RUN, SHALTn=1, SHALTACn=1, SUBSELn=1, BUSY=1, TOUT=0, counters=0.
REQ-031 Reset asserted mid-HALTED SHALL release the sub CPU immediately; no RELEASE cycle is required.
REQ-032 HALT_REQ held at 1 across reset deassertion SHALL enter HALT_WAIT on the first clock edge after RSTn=1.

Structure
REQ-033 The state encoding and the SETTLE and TIMEOUT defaults SHALL live in a shared fm7 package.
REQ-034 The saturating counter SHALL be a single sub-module, sat_cnt, instantiated twice (widths 4 and 10).
REQ-035 The RAM and address/data muxing stay outside this block; this block only produces the steering strobes.

Verification
REQ-036 HALT_REQ=1 with BA=BS=1 from the next cycle, SETTLE=2 -> SHALTn=0 at T+1, SHALTACn=0 at T+3, BUSY=0.
REQ-037 In HALTED, MSHRn=MSTBn=0 for one cycle -> SUBSELn=0 in that same cycle only.
REQ-038 HALT_REQ drops mid-access -> SHALTn stays 0 until one cycle after MSTBn=1; SUBSELn is never glitched high during the access.
REQ-039 HALT_REQ=1, BA=BS=0 held, TIMEOUT=8 -> TOUT=1 at cycle 8 and stays set; a HALT_REQ 0->1 in RUN clears it.
REQ-040 BS drops for 1 cycle while HALTED -> return to HALT_WAIT, SUBSELn=1, re-acknowledge after SETTLE cycles.
REQ-041 RSTn pulse while HALTED -> SHALTn=1 and SUBSELn=1 asynchronously; state=RUN.
